// File: rtl/axi4_lite_master_ctrl.sv
// axi4_lite_master_ctrl: single-outstanding AXI4-Lite master driven by a valid/ready command port.
// Every AXI and response output is registered; cmd_ready is decoded from the state register.
module axi4_lite_master_ctrl #(
    parameter int ADDRESS_WIDTH  = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                      ACLK,
    input  logic                      ARESETN,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [ADDRESS_WIDTH-1:0]  cmd_addr,
    input  logic [DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,
    output logic                      rsp_valid,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                rsp_resp,
    output logic                      rsp_timeout,
    output logic [ADDRESS_WIDTH-1:0]  M_AXI_ARADDR,
    output logic                      M_AXI_ARVALID,
    input  logic                      M_AXI_ARREADY,
    input  logic [DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                M_AXI_RRESP,
    input  logic                      M_AXI_RVALID,
    output logic                      M_AXI_RREADY,
    output logic [ADDRESS_WIDTH-1:0]  M_AXI_AWADDR,
    output logic                      M_AXI_AWVALID,
    input  logic                      M_AXI_AWREADY,
    output logic [DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                      M_AXI_WVALID,
    input  logic                      M_AXI_WREADY,
    input  logic [1:0]                M_AXI_BRESP,
    input  logic                      M_AXI_BVALID,
    output logic                      M_AXI_BREADY
);

    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE} state_t;

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] T_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    state_t        state;
    logic          aw_done;
    logic          w_done;
    logic [CW-1:0] cnt;
    logic          ar_hs;
    logic          r_hs;
    logic          aw_hs;
    logic          w_hs;
    logic          b_hs;
    logic          expired;

    assign cmd_ready = (state == IDLE);
    assign ar_hs     = M_AXI_ARVALID & M_AXI_ARREADY;
    assign r_hs      = M_AXI_RVALID & M_AXI_RREADY;
    assign aw_hs     = M_AXI_AWVALID & M_AXI_AWREADY;
    assign w_hs      = M_AXI_WVALID & M_AXI_WREADY;
    assign b_hs      = M_AXI_BVALID & M_AXI_BREADY;
    // Only the response phases are bounded; a zero parameter disables the abort entirely.
    assign expired   = (TIMEOUT_CYCLES > 0) && (cnt == T_LAST);

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state         <= IDLE;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            cnt           <= '0;
            rsp_valid     <= 1'b0;
            rsp_rdata     <= '0;
            rsp_resp      <= 2'b00;
            rsp_timeout   <= 1'b0;
            M_AXI_ARADDR  <= '0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b0;
            M_AXI_AWADDR  <= '0;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WDATA   <= '0;
            M_AXI_WSTRB   <= '0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_write) begin
                        M_AXI_AWADDR  <= cmd_addr;
                        M_AXI_WDATA   <= cmd_wdata;
                        M_AXI_WSTRB   <= cmd_wstrb;
                        M_AXI_AWVALID <= 1'b1;
                        M_AXI_WVALID  <= 1'b1;
                        aw_done       <= 1'b0;
                        w_done        <= 1'b0;
                        state         <= WR_REQ;
                    end else if (cmd_valid) begin
                        M_AXI_ARADDR  <= cmd_addr;
                        M_AXI_ARVALID <= 1'b1;
                        state         <= RD_ADDR;
                    end
                end
                RD_ADDR: begin
                    if (ar_hs) begin
                        M_AXI_ARVALID <= 1'b0;
                        M_AXI_RREADY  <= 1'b1;
                        cnt           <= '0;
                        state         <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (r_hs) begin
                        M_AXI_RREADY <= 1'b0;
                        rsp_rdata    <= M_AXI_RDATA;
                        rsp_resp     <= M_AXI_RRESP;
                        rsp_timeout  <= 1'b0;
                        rsp_valid    <= 1'b1;
                        state        <= DONE;
                    end else if (expired) begin
                        M_AXI_RREADY <= 1'b0;
                        rsp_rdata    <= '0;
                        rsp_resp     <= 2'b10;
                        rsp_timeout  <= 1'b1;
                        rsp_valid    <= 1'b1;
                        state        <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WR_REQ: begin
                    // AW and W complete independently; each VALID drops right after its own handshake.
                    if (aw_hs) begin
                        M_AXI_AWVALID <= 1'b0;
                        aw_done       <= 1'b1;
                    end
                    if (w_hs) begin
                        M_AXI_WVALID <= 1'b0;
                        w_done       <= 1'b1;
                    end
                    if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                        M_AXI_BREADY <= 1'b1;
                        cnt          <= '0;
                        state        <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (b_hs) begin
                        M_AXI_BREADY <= 1'b0;
                        rsp_rdata    <= '0;
                        rsp_resp     <= M_AXI_BRESP;
                        rsp_timeout  <= 1'b0;
                        rsp_valid    <= 1'b1;
                        state        <= DONE;
                    end else if (expired) begin
                        M_AXI_BREADY <= 1'b0;
                        rsp_rdata    <= '0;
                        rsp_resp     <= 2'b10;
                        rsp_timeout  <= 1'b1;
                        rsp_valid    <= 1'b1;
                        state        <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_lite_master_ctrl.sv
// tb_axi4_lite_master_ctrl: directed bench for the AXI4-Lite master with a scripted slave.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_axi4_lite_master_ctrl;

    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        rsp_timeout;
    logic [31:0] M_AXI_ARADDR;
    logic        M_AXI_ARVALID;
    logic        M_AXI_ARREADY;
    logic [31:0] M_AXI_RDATA;
    logic [1:0]  M_AXI_RRESP;
    logic        M_AXI_RVALID;
    logic        M_AXI_RREADY;
    logic [31:0] M_AXI_AWADDR;
    logic        M_AXI_AWVALID;
    logic        M_AXI_AWREADY;
    logic [31:0] M_AXI_WDATA;
    logic [3:0]  M_AXI_WSTRB;
    logic        M_AXI_WVALID;
    logic        M_AXI_WREADY;
    logic [1:0]  M_AXI_BRESP;
    logic        M_AXI_BVALID;
    logic        M_AXI_BREADY;

    int checks = 0;
    int errors = 0;

    axi4_lite_master_ctrl #(
        .ADDRESS_WIDTH(32),
        .DATA_WIDTH(32),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .ACLK(ACLK),
        .ARESETN(ARESETN),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata),
        .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp),
        .rsp_timeout(rsp_timeout),
        .M_AXI_ARADDR(M_AXI_ARADDR),
        .M_AXI_ARVALID(M_AXI_ARVALID),
        .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RDATA(M_AXI_RDATA),
        .M_AXI_RRESP(M_AXI_RRESP),
        .M_AXI_RVALID(M_AXI_RVALID),
        .M_AXI_RREADY(M_AXI_RREADY),
        .M_AXI_AWADDR(M_AXI_AWADDR),
        .M_AXI_AWVALID(M_AXI_AWVALID),
        .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA),
        .M_AXI_WSTRB(M_AXI_WSTRB),
        .M_AXI_WVALID(M_AXI_WVALID),
        .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BRESP(M_AXI_BRESP),
        .M_AXI_BVALID(M_AXI_BVALID),
        .M_AXI_BREADY(M_AXI_BREADY)
    );

    always #5 ACLK = ~ACLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    initial begin
        ARESETN = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
        M_AXI_ARREADY = 1'b0; M_AXI_RDATA = '0; M_AXI_RRESP = '0; M_AXI_RVALID = 1'b0;
        M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_BRESP = '0; M_AXI_BVALID = 1'b0;
        tick();
        tick();
        check("rst_arvalid", 32'(M_AXI_ARVALID), 32'd0);
        check("rst_awvalid", 32'(M_AXI_AWVALID), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        ARESETN = 1'b1;
        tick();

        // read 0x10, immediate ARREADY, RVALID the cycle after
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h10; M_AXI_ARREADY = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check("rd_arvalid", 32'(M_AXI_ARVALID), 32'd1);
        check("rd_araddr", M_AXI_ARADDR, 32'h10);
        check("rd_cmd_ready_busy", 32'(cmd_ready), 32'd0);
        check("rd_rready_early", 32'(M_AXI_RREADY), 32'd0);
        tick();
        check("rd_arvalid_drop", 32'(M_AXI_ARVALID), 32'd0);
        check("rd_rready", 32'(M_AXI_RREADY), 32'd1);
        check("rd_rsp_early", 32'(rsp_valid), 32'd0);
        M_AXI_ARREADY = 1'b0; M_AXI_RVALID = 1'b1; M_AXI_RDATA = 32'hDEADBEEF; M_AXI_RRESP = 2'b00;
        tick();
        M_AXI_RVALID = 1'b0;
        check("rd_rsp_valid", 32'(rsp_valid), 32'd1);
        check("rd_rdata", rsp_rdata, 32'hDEADBEEF);
        check("rd_resp", 32'(rsp_resp), 32'd0);
        check("rd_timeout", 32'(rsp_timeout), 32'd0);
        check("rd_rready_drop", 32'(M_AXI_RREADY), 32'd0);
        tick();
        check("rd_rsp_pulse", 32'(rsp_valid), 32'd0);
        check("rd_cmd_ready", 32'(cmd_ready), 32'd1);

        // write 0x20, WREADY at once, AWREADY after 3 cycles, BRESP=SLVERR
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h20; cmd_wdata = 32'hA5A55A5A; cmd_wstrb = 4'hF;
        M_AXI_WREADY = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check("wr_awvalid_c1", 32'(M_AXI_AWVALID), 32'd1);
        check("wr_wvalid_c1", 32'(M_AXI_WVALID), 32'd1);
        check("wr_awaddr", M_AXI_AWADDR, 32'h20);
        check("wr_wdata", M_AXI_WDATA, 32'hA5A55A5A);
        check("wr_wstrb", 32'(M_AXI_WSTRB), 32'hF);
        tick();
        M_AXI_WREADY = 1'b0;
        check("wr_wvalid_drop", 32'(M_AXI_WVALID), 32'd0);
        check("wr_awvalid_c2", 32'(M_AXI_AWVALID), 32'd1);
        check("wr_bready_early", 32'(M_AXI_BREADY), 32'd0);
        tick();
        check("wr_awvalid_c3", 32'(M_AXI_AWVALID), 32'd1);
        check("wr_awaddr_hold", M_AXI_AWADDR, 32'h20);
        M_AXI_AWREADY = 1'b1;
        tick();
        M_AXI_AWREADY = 1'b0;
        check("wr_awvalid_drop", 32'(M_AXI_AWVALID), 32'd0);
        check("wr_bready", 32'(M_AXI_BREADY), 32'd1);
        M_AXI_BVALID = 1'b1; M_AXI_BRESP = 2'b10;
        tick();
        M_AXI_BVALID = 1'b0;
        check("wr_rsp_valid", 32'(rsp_valid), 32'd1);
        check("wr_resp", 32'(rsp_resp), 32'd2);
        check("wr_rdata_zero", rsp_rdata, 32'd0);
        check("wr_bready_drop", 32'(M_AXI_BREADY), 32'd0);
        tick();

        // write with AW and W in the same cycle: response 3 cycles after accept
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h24; cmd_wdata = 32'h01234567; cmd_wstrb = 4'h3;
        M_AXI_AWREADY = 1'b1; M_AXI_WREADY = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check("wr2_wstrb", 32'(M_AXI_WSTRB), 32'h3);
        tick();
        M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0;
        check("wr2_both_drop", {30'd0, M_AXI_AWVALID, M_AXI_WVALID}, 32'd0);
        check("wr2_bready", 32'(M_AXI_BREADY), 32'd1);
        M_AXI_BVALID = 1'b1; M_AXI_BRESP = 2'b00;
        tick();
        M_AXI_BVALID = 1'b0;
        check("wr2_rsp_valid", 32'(rsp_valid), 32'd1);
        check("wr2_resp", 32'(rsp_resp), 32'd0);
        tick();

        // read with RVALID never returned: abort after 8 cycles in the data phase
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h40; M_AXI_ARREADY = 1'b1;
        M_AXI_RDATA = 32'h55AA55AA;
        tick();
        cmd_valid = 1'b0;
        tick();
        M_AXI_ARREADY = 1'b0;
        check("to_rready", 32'(M_AXI_RREADY), 32'd1);
        for (int i = 0; i < 7; i++) tick();
        check("to_rready_c7", 32'(M_AXI_RREADY), 32'd1);
        check("to_rsp_early", 32'(rsp_valid), 32'd0);
        tick();
        check("to_rready_drop", 32'(M_AXI_RREADY), 32'd0);
        check("to_rsp_valid", 32'(rsp_valid), 32'd1);
        check("to_timeout", 32'(rsp_timeout), 32'd1);
        check("to_resp", 32'(rsp_resp), 32'd2);
        check("to_rdata", rsp_rdata, 32'd0);
        tick();
        check("to_cmd_ready", 32'(cmd_ready), 32'd1);

        // reset asserted while waiting in WR_RESP
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h80; cmd_wdata = 32'hCAFEF00D; cmd_wstrb = 4'hF;
        M_AXI_AWREADY = 1'b1; M_AXI_WREADY = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0;
        check("rs_bready_before", 32'(M_AXI_BREADY), 32'd1);
        #2;
        ARESETN = 1'b0;
        #1;
        check("rs_bready", 32'(M_AXI_BREADY), 32'd0);
        check("rs_awaddr", M_AXI_AWADDR, 32'd0);
        check("rs_wdata", M_AXI_WDATA, 32'd0);
        check("rs_rsp_valid", 32'(rsp_valid), 32'd0);
        M_AXI_BVALID = 1'b1;
        tick();
        ARESETN = 1'b1;
        M_AXI_BVALID = 1'b0;
        check("rs_cmd_ready", 32'(cmd_ready), 32'd1);
        tick();
        check("rs_no_rsp", 32'(rsp_valid), 32'd0);
        check("rs_cmd_ready_hold", 32'(cmd_ready), 32'd1);

        // two back-to-back reads with cmd_valid held; RVALID held high throughout
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h100;
        M_AXI_ARREADY = 1'b1; M_AXI_RVALID = 1'b1; M_AXI_RDATA = 32'h11111111; M_AXI_RRESP = 2'b11;
        tick();
        cmd_addr = 32'h104;
        check("bb_araddr1", M_AXI_ARADDR, 32'h100);
        check("bb_rready_in_addr", 32'(M_AXI_RREADY), 32'd0);
        tick();
        tick();
        check("bb_rsp1_valid", 32'(rsp_valid), 32'd1);
        check("bb_rsp1_rdata", rsp_rdata, 32'h11111111);
        check("bb_rsp1_resp", 32'(rsp_resp), 32'd3);
        check("bb_no_ar_overlap", 32'(M_AXI_ARVALID), 32'd0);
        M_AXI_RDATA = 32'h22222222; M_AXI_RRESP = 2'b01;
        tick();
        check("bb_cmd_ready2", 32'(cmd_ready), 32'd1);
        check("bb_arvalid_idle", 32'(M_AXI_ARVALID), 32'd0);
        tick();
        cmd_valid = 1'b0;
        check("bb_arvalid2", 32'(M_AXI_ARVALID), 32'd1);
        check("bb_araddr2", M_AXI_ARADDR, 32'h104);
        tick();
        tick();
        check("bb_rsp2_valid", 32'(rsp_valid), 32'd1);
        check("bb_rsp2_rdata", rsp_rdata, 32'h22222222);
        check("bb_rsp2_resp", 32'(rsp_resp), 32'd1);
        M_AXI_RVALID = 1'b0; M_AXI_ARREADY = 1'b0;
        tick();
        check("bb_end_idle", 32'(cmd_ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
